clock_set_controller: RTL

- Timekeeping and set-mode controller for the 8-digit seven-segment clock display.
- Generates the hour/minute/second values and the digit-enable mask that feed the clock display controller.
- Runs a prescaled 1 Hz time base with an HH:MM:SS carry chain.
- A button-driven state machine lets the user step through the fields and increment each one.

---
 rtl/clock_set_pkg.sv | 49 ++++
 rtl/mod_counter.sv | 40 ++++
 rtl/clock_set_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_pkg.sv
// Shared types and constants for the clock set-mode controller.
// The optional blinking of the edited field is compiled in with the
// macro CLOCK_SET_CONTROLLER_BLINK_EN (see clock_set_controller.sv).
package clock_set_pkg;

    // Controller state; the numeric value is exported on the mode port.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    // Largest legal value of each time field.
    localparam logic [7:0] HOUR_MAX = 8'd23;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] SEC_MAX  = 8'd59;

    // Digit-enable masks: digits 7..2 show HH MM SS, digits 1:0 stay dark.
    localparam logic [7:0] EN_ALL      = 8'b1111_1100;
    localparam logic [7:0] HOUR_DIGITS = 8'b1100_0000;
    localparam logic [7:0] MIN_DIGITS  = 8'b0011_0000;
    localparam logic [7:0] SEC_DIGITS  = 8'b0000_1100;

    // Digits belonging to the field edited in a given state (none in RUN).
    function automatic logic [7:0] field_digits(input state_t s);
        logic [7:0] m;
        case (s)
            SET_HOUR: m = HOUR_DIGITS;
            SET_MIN:  m = MIN_DIGITS;
            SET_SEC:  m = SEC_DIGITS;
            default:  m = 8'h00;
        endcase
        return m;
    endfunction

    // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
    function automatic state_t next_mode(input state_t s);
        state_t n;
        case (s)
            RUN:      n = SET_HOUR;
            SET_HOUR: n = SET_MIN;
            SET_MIN:  n = SET_SEC;
            default:  n = RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter 0..MAX used for each time field. carry flags the
// increment that wraps MAX back to 0 so fields can be chained.
module mod_counter #(
    parameter logic [7:0] MAX = 8'd59
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next value: clear wins, otherwise increment with wrap at MAX.
    // The >= guard keeps the field in range even from a corrupted value.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 8'd0;
        end else if (inc) begin
            value_d = (value_q >= MAX) ? 8'd0 : value_q + 8'd1;
        end
    end

    // Field register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            value_q <= 8'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc & (value_q == MAX);

endmodule

// File: rtl/clock_set_controller.sv
// Timekeeping and set-mode controller for the 8-digit clock display.
// A prescaler derives a 1 Hz tick in RUN that drives an HH:MM:SS carry
// chain; the mode button steps through SET_HOUR/SET_MIN/SET_SEC where the
// inc button bumps the selected field without carry.
// Optional feature macro: CLOCK_SET_CONTROLLER_BLINK_EN blinks the digits
// of the field being edited; without it digit_en is constant.
//
// Button handshake: btn_mode/btn_inc are clean levels; a press is the
// single cycle where the level is high and was low on the previous clock.
// Holding a button yields one event. When both events coincide the mode
// event is taken and the increment is discarded.
module clock_set_controller
    import clock_set_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [7:0] digit_en,
    output logic [1:0] mode
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic mode_prev_q;
    logic inc_prev_q;
    logic mode_p;
    logic inc_p;
    logic inc_evt;

    // Remember last button levels to find rising edges.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
        end
    end

    assign mode_p  = btn_mode & ~mode_prev_q;
    assign inc_p   = btn_inc & ~inc_prev_q;
    assign inc_evt = inc_p & ~mode_p;

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   is_run;
    logic   sel_hour;
    logic   sel_min;
    logic   sel_sec;

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance one step per mode press.
    always_comb begin
        state_d = state_q;
        if (mode_p) begin
            state_d = next_mode(state_q);
        end
    end

    // State decode used by the prescaler and field counters.
    always_comb begin
        is_run   = 1'b0;
        sel_hour = 1'b0;
        sel_min  = 1'b0;
        sel_sec  = 1'b0;
        case (state_q)
            RUN:      is_run   = 1'b1;
            SET_HOUR: sel_hour = 1'b1;
            SET_MIN:  sel_min  = 1'b1;
            default:  sel_sec  = 1'b1;
        endcase
    end

    assign mode = state_q;

    // ------------------------------------------------------------------
    // 1 Hz prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    // Count only in RUN; parked at 0 while setting so the first second
    // after leaving set mode is a full CLK_HZ cycles long.
    always_comb begin
        tick    = is_run && (presc_q == PRESC_LAST);
        presc_d = '0;
        if (is_run && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Time fields
    // ------------------------------------------------------------------
    logic sec_inc;
    logic min_inc;
    logic hour_inc;
    logic sec_carry;
    logic min_carry;
    logic hour_carry;

    // Field increments: carry chain in RUN, single-field bump in SET.
    always_comb begin
        sec_inc  = (is_run & tick)      | (sel_sec  & inc_evt);
        min_inc  = (is_run & sec_carry) | (sel_min  & inc_evt);
        hour_inc = (is_run & min_carry) | (sel_hour & inc_evt);
    end

    mod_counter #(.MAX(SEC_MAX)) u_sec (
        .clock (clock),
        .rst   (rst),
        .inc   (sec_inc),
        .clr   (1'b0),
        .value (second),
        .carry (sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX)) u_min (
        .clock (clock),
        .rst   (rst),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (minute),
        .carry (min_carry)
    );

    mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .clock (clock),
        .rst   (rst),
        .inc   (hour_inc),
        .clr   (1'b0),
        .value (hour),
        .carry (hour_carry)
    );

    // The day rollover has nowhere to go.
    logic unused_hour_carry;
    assign unused_hour_carry = hour_carry;

    // ------------------------------------------------------------------
    // Digit enables
    // ------------------------------------------------------------------
`ifdef CLOCK_SET_CONTROLLER_BLINK_EN
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;
    logic          blink_phase_q;
    logic          blink_phase_d;
    logic [7:0]    digit_en_q;
    logic [7:0]    digit_en_d;

    // Blink timer: restart visible on any state change, in RUN, and on
    // every increment so the user always sees the new value first.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if ((state_d != state_q) || (state_d == RUN) || inc_evt) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    // Mask the edited field during the dark half of the blink.
    always_comb begin
        digit_en_d = EN_ALL;
        if (blink_phase_d) begin
            digit_en_d = EN_ALL & ~field_digits(state_d);
        end
    end

    // Blink and digit-enable registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            digit_en_q    <= EN_ALL;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            digit_en_q    <= digit_en_d;
        end
    end

    assign digit_en = digit_en_q;
`else
    // No blinking: all six time digits always lit.
    assign digit_en = EN_ALL;

    // BLINK_HALF only matters when blinking is compiled in.
    logic unused_blink_half;
    assign unused_blink_half = (BLINK_HALF == 0);
`endif

endmodule
